// File: rtl/hist_eq_frame_ctrl_if.sv
// Pixel handshake bundle between the upstream source, the frame controller and the equalizer core.
// The controller uses the master modport. The environment (source and core) uses the slave modport.
interface hist_eq_frame_ctrl_if;
   logic       src_valid;
   logic [7:0] src_gray;
   logic       src_ready;
   logic       core_valid;
   logic [7:0] core_gray;
   logic       core_end;
   logic       core_in_ready;
   logic       core_done;

   modport master (
      input  src_valid, src_gray, core_in_ready, core_done,
      output src_ready, core_valid, core_gray, core_end
   );

   modport slave (
      output src_valid, src_gray, core_in_ready, core_done,
      input  src_ready, core_valid, core_gray, core_end
   );
endinterface

// File: rtl/hist_eq_frame_ctrl.sv
// Frame sequencer for a histogram equalizer. It alternates learn frames, LUT builds and
// stream frames that reuse the LUT, and forwards pixels to the core with a one-cycle latency.
module hist_eq_frame_ctrl #(
   parameter int unsigned WIDTH         = 320,
   parameter int unsigned HEIGHT        = 240,
   parameter int unsigned BUILD_TIMEOUT = 1024
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   hist_eq_frame_ctrl_if.master        bus,
   input  logic                        i_relearn_req,
   input  logic [3:0]                  i_reuse_cnt,
   output logic [1:0]                  o_state,
   output logic [15:0]                 o_frame_cnt,
   output logic                        o_err_timeout
);

   localparam int unsigned TOTAL = WIDTH * HEIGHT;
   localparam int unsigned TmoW  = (BUILD_TIMEOUT > 1) ? $clog2(BUILD_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLearn  = 2'd1,
      StBuild  = 2'd2,
      StStream = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [16:0]     pix_cnt_q, pix_cnt_d;
   logic [3:0]      use_cnt_q, use_cnt_d;
   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            lut_valid_q, lut_valid_d;
   logic            relearn_q, relearn_d;
   logic            core_valid_q, core_valid_d;
   logic [7:0]      core_gray_q, core_gray_d;
   logic            core_end_q, core_end_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic            err_q, err_d;

   logic src_ready;
   logic xfer;
   logic last_px;

   assign src_ready = ((state_q == StLearn) || (state_q == StStream)) && bus.core_in_ready;
   assign xfer      = bus.src_valid && src_ready;
   assign last_px   = xfer && (pix_cnt_q == 17'(TOTAL - 1));

   always_comb begin
      state_d      = state_q;
      pix_cnt_d    = pix_cnt_q;
      use_cnt_d    = use_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      lut_valid_d  = lut_valid_q;
      relearn_d    = relearn_q;
      frame_cnt_d  = frame_cnt_q;
      err_d        = err_q;
      core_valid_d = xfer;
      core_gray_d  = xfer ? bus.src_gray : core_gray_q;
      core_end_d   = last_px;

      if (xfer) begin
         pix_cnt_d = last_px ? 17'd0 : pix_cnt_q + 17'd1;
      end
      if (last_px) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end

      case (state_q)
         StIdle: begin
            // A zero reuse count forces a learn frame even when the LUT is valid.
            if (bus.src_valid) begin
               if (!lut_valid_q || relearn_q || (i_reuse_cnt == 4'd0)) begin
                  state_d   = StLearn;
                  relearn_d = 1'b0;
               end else begin
                  state_d = StStream;
               end
            end
         end
         StLearn: begin
            if (last_px) begin
               state_d   = StBuild;
               tmo_cnt_d = '0;
            end
         end
         StBuild: begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            if (bus.core_done) begin
               lut_valid_d = 1'b1;
               use_cnt_d   = 4'd0;
               state_d     = StIdle;
            end else if (tmo_cnt_q == TmoW'(BUILD_TIMEOUT - 1)) begin
               err_d       = 1'b1;
               lut_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         StStream: begin
            if (last_px) begin
               state_d   = StIdle;
               use_cnt_d = (use_cnt_q == 4'd15) ? 4'd15 : use_cnt_q + 4'd1;
               if (((5'(use_cnt_q) + 5'd1) >= 5'(i_reuse_cnt)) || relearn_q) begin
                  lut_valid_d = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A new request overrides the clear applied on learn entry.
      if (i_relearn_req) begin
         relearn_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= StIdle;
         pix_cnt_q    <= '0;
         use_cnt_q    <= '0;
         tmo_cnt_q    <= '0;
         lut_valid_q  <= 1'b0;
         relearn_q    <= 1'b0;
         core_valid_q <= 1'b0;
         core_gray_q  <= '0;
         core_end_q   <= 1'b0;
         frame_cnt_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pix_cnt_q    <= pix_cnt_d;
         use_cnt_q    <= use_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         lut_valid_q  <= lut_valid_d;
         relearn_q    <= relearn_d;
         core_valid_q <= core_valid_d;
         core_gray_q  <= core_gray_d;
         core_end_q   <= core_end_d;
         frame_cnt_q  <= frame_cnt_d;
         err_q        <= err_d;
      end
   end

   assign bus.src_ready  = src_ready;
   assign bus.core_valid = core_valid_q;
   assign bus.core_gray  = core_gray_q;
   assign bus.core_end   = core_end_q;
   assign o_state        = state_q;
   assign o_frame_cnt    = frame_cnt_q;
   assign o_err_timeout  = err_q;

endmodule

// File: tb/tb_hist_eq_frame_ctrl.sv
// Directed bench for hist_eq_frame_ctrl at 4x2 pixels per frame with a 16-cycle build timeout.
// Expected pixels are queued when driven and compared when the core side presents them.
module tb_hist_eq_frame_ctrl;

   localparam int Total = 8;
   localparam logic [1:0] SIdle = 2'd0, SLearn = 2'd1, SBuild = 2'd2, SStream = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        relearn;
   logic [3:0]  reuse;
   logic [1:0]  o_state;
   logic [15:0] o_frame_cnt;
   logic        o_err;

   int total = 0;
   int bad   = 0;
   int fc_exp = 0;
   logic [8:0] sb[$];
   logic [8:0] mon_e;

   hist_eq_frame_ctrl_if bus ();

   hist_eq_frame_ctrl #(
      .WIDTH         (4),
      .HEIGHT        (2),
      .BUILD_TIMEOUT (16)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .bus           (bus.master),
      .i_relearn_req (relearn),
      .i_reuse_cnt   (reuse),
      .o_state       (o_state),
      .o_frame_cnt   (o_frame_cnt),
      .o_err_timeout (o_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Core-side monitor, sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (bus.core_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("core_gray", 32'(bus.core_gray), 32'(mon_e[8:1]));
            check("core_end", 32'(bus.core_end), 32'(mon_e[0]));
         end
      end
   end

   // Presents a frame: one IDLE decision cycle, then npix transfers.
   task automatic frame(input logic [1:0] st, input int npix, input int stall_at, input int rl_at);
      @(negedge clk);
      bus.src_valid     = 1'b1;
      bus.core_in_ready = 1'b1;
      #1;
      check("idle_state", 32'(o_state), 32'(SIdle));
      check("idle_ready", 32'(bus.src_ready), 32'd0);
      for (int i = 0; i < npix; i++) begin
         if (i == stall_at) begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               bus.core_in_ready = 1'b0;
               relearn           = 1'b0;
               #1;
               check("stall_ready", 32'(bus.src_ready), 32'd0);
               check("stall_state", 32'(o_state), 32'(st));
            end
         end
         @(negedge clk);
         bus.core_in_ready = 1'b1;
         relearn           = (i == rl_at);
         bus.src_gray      = 8'($urandom_range(1, 255));
         #1;
         check("px_state", 32'(o_state), 32'(st));
         check("px_ready", 32'(bus.src_ready), 32'd1);
         sb.push_back({bus.src_gray, (i == Total - 1)});
         if (i == Total - 1) fc_exp++;
      end
   endtask

   task automatic end_frame(input logic [1:0] st);
      @(negedge clk);
      bus.src_valid = 1'b0;
      relearn       = 1'b0;
      #1;
      check("post_state", 32'(o_state), 32'(st));
      check("frame_cnt", 32'(o_frame_cnt), 32'(fc_exp));
   endtask

   // end_frame already observed the first BUILD cycle.
   task automatic build_done(input int n);
      for (int k = 1; k < n; k++) begin
         @(negedge clk);
         #1;
         check("build_state", 32'(o_state), 32'(SBuild));
      end
      @(negedge clk);
      bus.core_done = 1'b1;
      #1;
      check("build_state", 32'(o_state), 32'(SBuild));
      @(negedge clk);
      bus.core_done = 1'b0;
      #1;
      check("done_idle", 32'(o_state), 32'(SIdle));
   endtask

   task automatic build_timeout();
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         #1;
         check("tmo_build", 32'(o_state), 32'(SBuild));
      end
      @(negedge clk);
      #1;
      check("tmo_idle", 32'(o_state), 32'(SIdle));
      check("tmo_err", 32'(o_err), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(bus.core_valid), 32'd0);
      check({tag, "_gray"}, 32'(bus.core_gray), 32'd0);
      check({tag, "_end"}, 32'(bus.core_end), 32'd0);
      check({tag, "_fcnt"}, 32'(o_frame_cnt), 32'd0);
      check({tag, "_err"}, 32'(o_err), 32'd0);
      check({tag, "_state"}, 32'(o_state), 32'(SIdle));
      check({tag, "_ready"}, 32'(bus.src_ready), 32'd0);
   endtask

   initial begin
      rst               = 1'b1;
      relearn           = 1'b0;
      reuse             = 4'd2;
      bus.src_valid     = 1'b0;
      bus.src_gray      = 8'd0;
      bus.core_in_ready = 1'b1;
      bus.core_done     = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero("reset");

      // A done pulse outside BUILD must not validate the LUT.
      @(negedge clk);
      bus.core_done = 1'b1;
      @(negedge clk);
      bus.core_done = 1'b0;

      // Reuse of 2: LEARN, STREAM, STREAM, LEARN.
      frame(SLearn, Total, -1, -1);
      end_frame(SBuild);
      build_done(5);
      frame(SStream, Total, -1, -1);
      end_frame(SIdle);
      frame(SStream, Total, -1, -1);
      end_frame(SIdle);
      frame(SLearn, Total, -1, -1);
      end_frame(SBuild);
      build_done(3);

      // Relearn request mid-stream, then a learn frame with a 3-cycle core stall.
      reuse = 4'd8;
      frame(SStream, Total, -1, 3);
      end_frame(SIdle);
      frame(SLearn, Total, 4, -1);
      end_frame(SBuild);
      build_done(2);

      // Zero reuse count forces learning even with a valid LUT.
      reuse = 4'd0;
      frame(SLearn, Total, -1, -1);
      end_frame(SBuild);
      build_done(1);
      frame(SLearn, Total, -1, -1);
      end_frame(SBuild);
      build_timeout();

      // After a timeout the LUT is invalid; the error flag stays set.
      reuse = 4'd2;
      frame(SLearn, Total, -1, -1);
      end_frame(SBuild);
      build_done(4);
      check("err_sticky", 32'(o_err), 32'd1);

      // Reset five transfers into a stream frame.
      frame(SStream, 5, -1, -1);
      @(negedge clk);
      bus.src_valid = 1'b0;
      rst           = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      fc_exp = 0;
      #1;
      check_zero("midreset");
      frame(SLearn, Total, -1, -1);
      end_frame(SBuild);
      build_done(2);

      repeat (2) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
